// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header + big-endian words, holds the CPU until loaded.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            cpu_run,
  output logic            busy,
  output logic            error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CSUM;
`else
  localparam state_e AFTER_DATA = DONE;
`endif

  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_q, word_d;
  logic [1:0]            byte_q, byte_d;
  logic [23:0]           shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  run_q, run_d;
  logic [7:0]            sum_q, sum_d;
  logic                  rx_ready_w;
  logic                  hs;
  logic [15:0]           len_full;

  assign rx_ready_w    = !reset && (state_q != DONE) && (state_q != ERR);
  assign hs            = bus.rx_valid && rx_ready_w;
  assign len_full      = {len_q[15:8], bus.rx_data};

  assign bus.rx_ready  = rx_ready_w;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_run       = run_q;
  assign busy          = (state_q != HDR_HI) && (state_q != DONE) && (state_q != ERR);
  assign error         = (state_q == ERR);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    run_d   = (state_q == DONE);

    case (state_q)
      HDR_HI: if (hs) begin
        len_d[15:8] = bus.rx_data;
        state_d     = HDR_LO;
      end
      HDR_LO: if (hs) begin
        len_d[7:0] = bus.rx_data;
        word_d     = '0;
        byte_d     = '0;
        sum_d      = '0;
        if (32'(len_full) > CAPACITY)  state_d = ERR;
        else if (len_full == 16'd0)    state_d = AFTER_DATA;
        else                           state_d = DATA;
      end
      DATA: if (hs) begin
        sum_d = sum_q + bus.rx_data;
        if (byte_q == 2'd3) begin
          // Word complete: strobe next cycle, addr/data hold until the next write.
          wdata_d = {shift_q, bus.rx_data};
          addr_d  = word_q[ADDR_WIDTH-1:0];
          we_d    = 1'b1;
          word_d  = word_q + (ADDR_WIDTH+1)'(1);
          byte_d  = '0;
          if (32'(word_d) == 32'(len_q)) state_d = AFTER_DATA;
        end else begin
          shift_d = {shift_q[15:0], bus.rx_data};
          byte_d  = byte_q + 2'd1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (hs) begin
        state_d = (8'(sum_q + bus.rx_data) == 8'd0) ? DONE : ERR;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR_HI;
      len_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads against a stream-level model.
module tb_imem_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0;
  logic reset;
  logic cpu_run, busy, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .cpu_run (cpu_run),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/flag monitor, sampled mid-cycle.
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            got_cyc[$];
  int            run_rise = -1;
  int            err_rise = -1;
  logic          prev_run = 1'b0;
  logic          prev_err = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr.push_back(bus.mem_addr);
      got_data.push_back(bus.mem_wdata);
      got_cyc.push_back(cyc);
    end
    if (cpu_run === 1'b1 && !prev_run) run_rise = cyc;
    if (error === 1'b1 && !prev_err) err_rise = cyc;
    prev_run = (cpu_run === 1'b1);
    prev_err = (error === 1'b1);
  end

  // Reference model outputs
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_run, exp_err;
  int            exp_last;
  int            hs_cyc[$];
  int            base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bq_t s);
    int len;
    int unsigned sum;
    exp_addr.delete();
    exp_data.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    len = int'({s[0], s[1]});
    if (len > DEPTH) begin
      exp_err  = 1'b1;
      exp_last = 1;
      return;
    end
    sum = 0;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      for (int k = 2; k < 6; k++) sum += s[k+4*i];
    end
    exp_last = 1 + 4 * len;
`ifdef LOADER_CHECKSUM_EN
    exp_last++;
    if ((sum + s[exp_last]) % 256 == 0) exp_run = 1'b1;
    else                                exp_err = 1'b1;
`else
    exp_run = 1'b1;
`endif
  endfunction

  function automatic bq_t make_stream(input wq_t w);
    bq_t s;
    logic [7:0] sum = 8'd0;
    s.push_back(8'(w.size() >> 8));
    s.push_back(8'(w.size()));
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        s.push_back(w[i][8*k +: 8]);
        sum += w[i][8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'(8'd0 - sum));
`endif
    return s;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_ready_timeout: observed ready low for %0d cycles, required handshake", n);
      bus.rx_valid = 1'b0;
      return;
    end
    hs_cyc.push_back(cyc);
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("ready_in_reset", bus.rx_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    hs_cyc.delete();
    base = got_addr.size();
  endtask

  // mode: 0 continuous, 1 valid toggling, 2 random gaps
  task automatic run_load(input string tag, input bq_t s, input int mode, input bit rst);
    int g, n;
    model(s);
    if (rst) do_reset();
    hs_cyc.delete();
    base = got_addr.size();
    foreach (s[i]) begin
      case (mode)
        0:       g = 0;
        1:       g = 1;
        default: g = int'($urandom_range(0, 2));
      endcase
      send(s[i], g);
    end
    idle(4);
    n = got_addr.size() - base;
    check({tag, "_nwrites"}, n, exp_addr.size());
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[base+i], exp_addr[i]);
      check({tag, "_data"}, got_data[base+i], exp_data[i]);
      if (5 + 4*i < hs_cyc.size())
        check({tag, "_we_cycle"}, got_cyc[base+i], hs_cyc[5+4*i] + 1);
    end
    check({tag, "_cpu_run"}, cpu_run, exp_run);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_ready"}, bus.rx_ready, 0);
    check({tag, "_busy"}, busy, 0);
    if (exp_last < hs_cyc.size()) begin
      if (exp_run) check({tag, "_run_rise"}, run_rise, hs_cyc[exp_last] + 2);
      if (exp_err) check({tag, "_err_rise"}, err_rise, hs_cyc[exp_last] + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wq_t w;
    bq_t s;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    do_reset();
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_ready", bus.rx_ready, 1);

    // Directed two-word image, continuous then toggling valid
    w = '{32'h20080005, 32'h00000008};
    s = make_stream(w);
    run_load("n2_cont", s, 0, 1'b0);

    // Bytes offered after DONE are refused and cause no writes
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("done_ready", bus.rx_ready, 0);
    end
    check("done_nwrites", got_addr.size() - base, 2);
    idle(1);

    run_load("n2_toggle", s, 1, 1'b1);

    // Oversize header -> ERR; exactly full memory -> 1024 writes
    s = '{8'h04, 8'h01};
    run_load("oversize", s, 0, 1'b1);
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom());
    s = make_stream(w);
    run_load("full", s, 0, 1'b1);

    // Empty image
    w.delete();
    s = make_stream(w);
    run_load("n0", s, 0, 1'b1);

    // Reset after six data bytes: one write survives, partial word dropped
    do_reset();
    w = '{$urandom(), $urandom()};
    s = make_stream(w);
    for (int i = 0; i < 8; i++) send(s[i], 0);
    @(negedge clk);
    check("mid_busy", busy, 1);
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("mid_ready_in_reset", bus.rx_ready, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_nwrites", got_addr.size() - base, 1);
    check("mid_addr", got_addr[base], 0);
    check("mid_data", got_data[base], w[0]);
    check("mid_ready", bus.rx_ready, 1);
    check("mid_busy_after", busy, 0);
    check("mid_cpu_run", cpu_run, 0);
    check("mid_mem_we", bus.mem_we, 0);
    w = '{$urandom()};
    s = make_stream(w);
    run_load("after_mid", s, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    w = '{32'h01020304};
    s = make_stream(w);
    run_load("csum_ok", s, 0, 1'b1);
    s[s.size()-1] = s[s.size()-1] + 8'd1;
    run_load("csum_bad", s, 0, 1'b1);
`endif

    // Random images with random valid gaps
    for (int t = 0; t < 6; t++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) w.push_back($urandom());
      s = make_stream(w);
      run_load("rand", s, 2, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle CPU. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS words, and writes them sequentially into the instruction memory read by the fetch stage. Holds the CPU stopped until the full image is written, then releases it; it sits directly upstream of instruction fetch.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width; capacity 2^ADDR_WIDTH words.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready on a rising edge.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address of the current write.
- mem_wdata  out  32  assembled instruction word.
- cpu_run  out  1  high once the image is loaded; gates CPU PC write and register/data-memory writes.
- busy  out  1  high while in HDR_HI..CSUM after the first byte has been accepted.
- error  out  1  sticky load error; cleared only by reset.

## Operation
- Stream format: length high byte, length low byte (16-bit word count N), then 4·N data bytes, MSB first per word, plus a trailing checksum byte when LOADER_CHECKSUM_EN is defined.
- States: HDR_HI, HDR_LO, DATA, CSUM (macro only), DONE, ERR.
- HDR_HI: accept byte -> len[15:8]; go HDR_LO.
- HDR_LO: accept byte -> len[7:0]. If len > 2^ADDR_WIDTH -> ERR. If len == 0 -> CSUM (macro) or DONE. Otherwise -> DATA with word index and byte index cleared.
- DATA: each accepted byte shifts into a 32-bit register, first byte ending in bits [31:24]. On the 4th byte of a word, capture the word and its index into mem_wdata/mem_addr, assert mem_we next cycle, increment the word index, and clear the byte index. After the last byte of word N-1 -> CSUM (macro) or DONE.
- DONE: rx_ready 0, cpu_run 1. Stays here until reset; further stream bytes are not accepted.
- ERR: rx_ready 0, error 1, cpu_run 0. Stays here until reset.
- rx_ready = 1 in HDR_HI, HDR_LO, DATA, CSUM; 0 in DONE and ERR, and 0 in any cycle with reset high.
- Word index is ADDR_WIDTH+1 bits internally so len == 2^ADDR_WIDTH fills memory exactly with no wrap. mem_addr carries the low ADDR_WIDTH bits.
- Reset mid-load: returns to HDR_HI with all counters and outputs cleared. Words already written stay in memory and are not erased. A partially assembled word is discarded with no write.

## Timing
- Reset values: rx_ready 0 while reset is high, then 1 (HDR_HI); mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, busy 0, error 0.
- Throughput: one byte per cycle when rx_valid is held high; no internal stalls.
- mem_we: high exactly the cycle after the 4th-byte handshake. mem_addr and mem_wdata are stable during that cycle and hold until the next write.
- Completion: the FSM enters DONE in the cycle of the final write strobe. cpu_run rises the following cycle, so the last write commits before the CPU fetches.
- ERR is entered the cycle after the offending handshake; error rises in that same cycle.
- A write strobe and a new byte handshake may coincide in the same cycle; both proceed.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - One extra byte follows the data (also sent for N == 0).
  - Required condition: (sum of all data bytes + checksum byte) mod 256 == 0; header bytes are excluded.
  - Match -> DONE; cpu_run rises the cycle after the CSUM handshake.
  - Mismatch -> ERR; words already written remain in memory.
- Undefined:
  - No CSUM state and no trailing byte.
  - DONE is entered directly after the last data word.

## Test plan
- N=2, bytes 0x00,0x02, 20 08 00 05, 00 00 00 08, rx_valid continuous -> mem_we pulses at addr 0 data 0x20080005 and addr 1 data 0x00000008; cpu_run rises one cycle after the second strobe; rx_ready then 0.
- Same image with rx_valid toggling every other cycle -> identical writes; no byte lost or duplicated.
- Header 0x04,0x01 with ADDR_WIDTH=10 (1025 > 1024) -> ERR the next cycle; error=1, no mem_we, cpu_run stays 0. Header 0x04,0x00 -> 1024 writes, last at addr 1023.
- N=0 -> no mem_we; cpu_run=1 (with macro defined: after checksum byte 0x00).
- Reset asserted after 6 data bytes -> one write at addr 0 only; after reset, state HDR_HI and a fresh N=1 load writes addr 0.
- With macro: N=1 word 0x01020304, checksum 0xF6 -> DONE, cpu_run=1. Checksum 0xF7 -> ERR, error=1, cpu_run=0.
